// File: rtl/gpio_param_mailbox_pkg.sv
// Shared opcodes and GP_IN/GP_OUT field positions for the GPIO command mailbox.
// pack_resp assembles a GP_OUT response word from its fields.
package gpio_param_mailbox_pkg;

  typedef enum logic [1:0] {
    OP_NOP   = 2'b00,
    OP_WR_LO = 2'b01,
    OP_WR_HI = 2'b10,
    OP_RD    = 2'b11
  } op_e;

  localparam int STROBE_BIT   = 31;
  localparam int OP_HI        = 30;
  localparam int OP_LO        = 29;
  localparam int ADDR_HI      = 28;
  localparam int ADDR_LO      = 24;
  localparam int DATA_HI      = 15;
  localparam int DATA_LO      = 0;
  localparam int ACK_BIT      = 31;
  localparam int ERR_BIT      = 30;
  localparam int ECHO_HI      = 29;
  localparam int ECHO_LO      = 25;
  localparam int ADDR_FIELD_W = ADDR_HI - ADDR_LO + 1;

  function automatic logic [31:0] pack_resp(input logic                    ack,
                                            input logic                    err,
                                            input logic [ADDR_FIELD_W-1:0] addr,
                                            input logic [15:0]             rdata);
    logic [31:0] r;
    r                  = '0;
    r[ACK_BIT]         = ack;
    r[ERR_BIT]         = err;
    r[ECHO_HI:ECHO_LO] = addr;
    r[DATA_HI:DATA_LO] = rdata;
    return r;
  endfunction

endpackage

// File: rtl/gpio_param_mailbox_if.sv
// PS GPIO command/response pair: the host drives GP_IN, the mailbox answers on GP_OUT.
interface gpio_param_mailbox_if;
  logic [31:0] GP_IN;
  logic [31:0] GP_OUT;

  modport master (output GP_IN, input GP_OUT);
  modport slave  (input GP_IN, output GP_OUT);
endinterface

// File: rtl/gpio_param_mailbox_sync.sv
// Two-flop synchroniser bringing the quasi-static GP_IN word into the ADC_CLK domain.
module gpio_sync #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/gpio_param_mailbox.sv
// Toggle-strobe command mailbox: host writes config registers in two 16-bit halves
// and reads back config/status words through a coherent snapshot.
module gpio_param_mailbox
  import gpio_param_mailbox_pkg::*;
#(
  parameter int                          FP_WIDTH   = 32,
  parameter int                          GPIO_WIDTH = 32,
  parameter int                          NUM_CFG    = 16,
  parameter int                          NUM_STAT   = 8,
  parameter int                          ADDR_WIDTH = 5,
  parameter logic [NUM_CFG*FP_WIDTH-1:0] CFG_RESET  = '0
) (
  input  logic                           ADC_CLK,
  input  logic                           REG_RST_N,
  gpio_param_mailbox_if.slave            gp,
  input  logic [NUM_STAT*FP_WIDTH-1:0]   STAT_IN,
  output logic [NUM_CFG*FP_WIDTH-1:0]    CFG_OUT,
  output logic                           CFG_UPDATE,
  output logic [ADDR_WIDTH-1:0]          CFG_WR_ADDR
);

  if (FP_WIDTH != 32 || GPIO_WIDTH != 32 || ADDR_WIDTH > ADDR_FIELD_W ||
      NUM_CFG + NUM_STAT > (1 << ADDR_WIDTH)) begin : g_param_check
    $error("gpio_param_mailbox: unsupported parameter combination");
  end

  logic [GPIO_WIDTH-1:0]   sync_q;
  logic                    prev_strobe;
  logic [1:0]              settle_cnt;
  logic                    cmd_valid;
  op_e                     cmd_op;
  logic [ADDR_FIELD_W-1:0] cmd_addr;
  logic [15:0]             cmd_data;
  logic                    in_cfg;
  logic                    in_map;
  logic [FP_WIDTH-1:0]     rd_word;
  logic [FP_WIDTH-1:0]     snapshot;
  logic [15:0]             shadow_lo;
  logic                    resp_err;
  logic [15:0]             resp_rdata;
  logic                    unused_gp_bits;

  gpio_sync #(.WIDTH(GPIO_WIDTH)) u_sync (
    .clk   (ADC_CLK),
    .rst_n (REG_RST_N),
    .d     (gp.GP_IN),
    .q     (sync_q)
  );

  // Edges are ignored until the synchroniser has refilled after reset, so a strobe
  // level left over from an aborted command is not mistaken for a new one.
  assign cmd_valid      = (settle_cnt == 2'd3) && (sync_q[STROBE_BIT] != prev_strobe);
  assign cmd_op         = op_e'(sync_q[OP_HI:OP_LO]);
  assign cmd_addr       = sync_q[ADDR_HI:ADDR_LO];
  assign cmd_data       = sync_q[DATA_HI:DATA_LO];
  assign in_cfg         = 32'(cmd_addr) < NUM_CFG;
  assign in_map         = 32'(cmd_addr) < NUM_CFG + NUM_STAT;
  assign unused_gp_bits = ^sync_q[ADDR_LO-1:DATA_HI+1];

  always_comb begin
    rd_word = '0;
    for (int k = 0; k < NUM_CFG; k++)
      if (32'(cmd_addr) == k) rd_word = CFG_OUT[k*FP_WIDTH +: FP_WIDTH];
    for (int k = 0; k < NUM_STAT; k++)
      if (32'(cmd_addr) == NUM_CFG + k) rd_word = STAT_IN[k*FP_WIDTH +: FP_WIDTH];
  end

  always_comb begin
    resp_err   = 1'b0;
    resp_rdata = '0;
    case (cmd_op)
      OP_WR_HI: resp_err = !in_cfg;
      OP_RD: begin
        if (!in_map)          resp_err   = 1'b1;
        else if (cmd_data[0]) resp_rdata = snapshot[FP_WIDTH-1 -: 16];
        else                  resp_rdata = rd_word[15:0];
      end
      default: ;
    endcase
  end

  always_ff @(posedge ADC_CLK or negedge REG_RST_N) begin
    if (!REG_RST_N) begin
      settle_cnt  <= '0;
      prev_strobe <= 1'b0;
      CFG_OUT     <= CFG_RESET;
      gp.GP_OUT   <= '0;
      CFG_UPDATE  <= 1'b0;
      CFG_WR_ADDR <= '0;
      shadow_lo   <= '0;
      snapshot    <= '0;
    end else begin
      if (settle_cnt != 2'd3) settle_cnt <= settle_cnt + 2'd1;
      prev_strobe <= sync_q[STROBE_BIT];
      CFG_UPDATE  <= 1'b0;
      if (cmd_valid) begin
        gp.GP_OUT <= pack_resp(~gp.GP_OUT[ACK_BIT], resp_err, cmd_addr, resp_rdata);
        case (cmd_op)
          OP_WR_LO: shadow_lo <= cmd_data;
          OP_WR_HI: begin
            if (in_cfg) begin
              for (int k = 0; k < NUM_CFG; k++)
                if (32'(cmd_addr) == k) CFG_OUT[k*FP_WIDTH +: FP_WIDTH] <= {cmd_data, shadow_lo};
              CFG_UPDATE  <= 1'b1;
              CFG_WR_ADDR <= ADDR_WIDTH'(cmd_addr);
            end
          end
          OP_RD: if (in_map && !cmd_data[0]) snapshot <= rd_word;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_gpio_param_mailbox.sv
// Bench for gpio_param_mailbox: directed scenarios on a 16/8 instance, then randomised
// traffic on a 4/2 instance, all compared every cycle against a command-level model.
module tb_gpio_param_mailbox;

  localparam logic [511:0] RST_B = 512'(32'h3F80_0000) << 96;
  localparam logic [127:0] RST_S = 128'h1111_0003_2222_0002_3333_0001_4444_0000;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  gpio_param_mailbox_if if_b();
  gpio_param_mailbox_if if_s();

  logic [31:0]  host_word = '0;
  logic [31:0]  stat_w [8];
  logic [255:0] stat_b;
  logic [63:0]  stat_s;
  logic [511:0] cfg_b;
  logic [127:0] cfg_s;
  logic         upd_b, upd_s;
  logic [4:0]   wr_b;
  logic [2:0]   wr_s;

  assign if_b.GP_IN = host_word;
  assign if_s.GP_IN = host_word;

  always_comb begin
    stat_b = '0;
    for (int k = 0; k < 8; k++) stat_b[32*k +: 32] = stat_w[k];
  end
  assign stat_s = stat_b[63:0];

  gpio_param_mailbox #(.NUM_CFG(16), .NUM_STAT(8), .ADDR_WIDTH(5), .CFG_RESET(RST_B)) dut_big (
    .ADC_CLK(clk), .REG_RST_N(rst_n), .gp(if_b), .STAT_IN(stat_b),
    .CFG_OUT(cfg_b), .CFG_UPDATE(upd_b), .CFG_WR_ADDR(wr_b));

  gpio_param_mailbox #(.NUM_CFG(4), .NUM_STAT(2), .ADDR_WIDTH(3), .CFG_RESET(RST_S)) dut_small (
    .ADC_CLK(clk), .REG_RST_N(rst_n), .gp(if_s), .STAT_IN(stat_s),
    .CFG_OUT(cfg_s), .CFG_UPDATE(upd_s), .CFG_WR_ADDR(wr_s));

  // Reference model: the mailbox as seen by the host, one update per executed command.
  logic        use_small = 1'b0;
  int          m_ncfg = 16, m_nstat = 8;
  logic [31:0] mdl_cfg [16];
  logic [15:0] mdl_shadow;
  logic [31:0] mdl_snap, mdl_gpout;
  logic        mdl_upd;
  logic [4:0]  mdl_wraddr;
  logic        chk_en = 1'b0;

  int checks = 0, errors = 0, strobes = 0, ack_toggles = 0, upd_pulses = 0;
  logic last_ack = 1'b0;

  logic [31:0] act_gpout;
  logic [31:0] act_cfg [16];
  logic        act_upd;
  logic [4:0]  act_wraddr;

  always_comb begin
    act_gpout  = use_small ? if_s.GP_OUT : if_b.GP_OUT;
    act_upd    = use_small ? upd_s : upd_b;
    act_wraddr = use_small ? {2'b00, wr_s} : wr_b;
    for (int k = 0; k < 16; k++) act_cfg[k] = use_small ? 32'h0 : cfg_b[32*k +: 32];
    if (use_small) for (int k = 0; k < 4; k++) act_cfg[k] = cfg_s[32*k +: 32];
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  task automatic modelReset();
    m_ncfg  = use_small ? 4 : 16;
    m_nstat = use_small ? 2 : 8;
    for (int k = 0; k < 16; k++) mdl_cfg[k] = use_small ? 32'h0 : RST_B[32*k +: 32];
    if (use_small) for (int k = 0; k < 4; k++) mdl_cfg[k] = RST_S[32*k +: 32];
    mdl_shadow = '0; mdl_snap = '0; mdl_gpout = '0; mdl_upd = 1'b0; mdl_wraddr = '0;
  endtask

  task automatic modelExec(input logic [1:0] op, input logic [4:0] addr, input logic [15:0] data);
    int          a   = int'(addr);
    logic        err = 1'b0;
    logic [15:0] rd  = '0;
    logic [31:0] w;
    case (op)
      2'd1: mdl_shadow = data;
      2'd2: begin
        if (a < m_ncfg) begin
          mdl_cfg[a] = {data, mdl_shadow};
          mdl_upd    = 1'b1;
          mdl_wraddr = addr;
        end else err = 1'b1;
      end
      2'd3: begin
        if (a >= m_ncfg + m_nstat) err = 1'b1;
        else if (data[0]) rd = mdl_snap[31:16];
        else begin
          w        = (a < m_ncfg) ? mdl_cfg[a] : stat_w[a - m_ncfg];
          mdl_snap = w;
          rd       = w[15:0];
        end
      end
      default: ;
    endcase
    mdl_gpout = {~mdl_gpout[31], err, addr, 9'd0, rd};
  endtask

  // Host transaction: fields first, strobe toggle in a separate write, result three edges later.
  task automatic applyStimulus(input logic [1:0] op, input logic [4:0] addr, input logic [15:0] data);
    @(posedge clk); #1;
    host_word[30:29] = op;
    host_word[28:24] = addr;
    host_word[15:0]  = data;
    @(posedge clk); #1;
    host_word[31] = ~host_word[31];
    strobes++;
    repeat (3) @(posedge clk);
    #1 modelExec(op, addr, data);
    @(posedge clk); #1 mdl_upd = 1'b0;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      checkOutput("gp_out", act_gpout, mdl_gpout);
      for (int k = 0; k < m_ncfg; k++)
        checkOutput($sformatf("cfg_out[%0d]", k), act_cfg[k], mdl_cfg[k]);
      checkOutput("cfg_update", 32'(act_upd), 32'(mdl_upd));
      checkOutput("cfg_wr_addr", 32'(act_wraddr), 32'(mdl_wraddr));
      if (act_gpout[31] != last_ack) ack_toggles++;
      last_ack = act_gpout[31];
      if (act_upd) upd_pulses++;
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int u0, a0, s0;
    logic [1:0]  r_op;
    logic [4:0]  r_addr;
    logic [15:0] r_data;

    for (int k = 0; k < 8; k++) stat_w[k] = 32'h5000_0000 + 32'(k);
    #2 rst_n = 1'b0;
    modelReset();
    chk_en = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    checkOutput("rst_cfg3", act_cfg[3], 32'h3F80_0000);
    checkOutput("rst_gp_out", act_gpout, 32'h0);

    $display("[TB] two-half write to reg8");
    u0 = upd_pulses; a0 = ack_toggles;
    applyStimulus(2'd1, 5'd8, 16'h1234);
    applyStimulus(2'd2, 5'd8, 16'h3DCC);
    checkOutput("reg8_value", act_cfg[8], 32'h3DCC_1234);
    checkOutput("reg8_wr_addr", 32'(act_wraddr), 32'd8);
    checkOutput("reg8_update_pulses", 32'(upd_pulses - u0), 32'd1);
    checkOutput("reg8_ack_toggles", 32'(ack_toggles - a0), 32'd2);

    $display("[TB] status read coherence");
    stat_w[0] = 32'hDEAD_BEEF;
    applyStimulus(2'd3, 5'd16, 16'h0000);
    checkOutput("stat_rd_lo", 32'(act_gpout[15:0]), 32'h0000_BEEF);
    stat_w[0] = 32'h0000_0000;
    applyStimulus(2'd3, 5'd16, 16'h0001);
    checkOutput("stat_rd_hi", 32'(act_gpout[15:0]), 32'h0000_DEAD);

    $display("[TB] error responses");
    u0 = upd_pulses;
    applyStimulus(2'd2, 5'd16, 16'hABCD);
    checkOutput("wr_status_err", 32'(act_gpout[30]), 32'd1);
    checkOutput("wr_status_no_update", 32'(upd_pulses - u0), 32'd0);
    applyStimulus(2'd3, 5'd31, 16'h0000);
    checkOutput("rd_unmapped_err_rdata", {15'd0, act_gpout[30], act_gpout[15:0]}, 32'h0001_0000);
    applyStimulus(2'd0, 5'd0, 16'h0000);
    checkOutput("nop_err_clear", 32'(act_gpout[30]), 32'd0);

    $display("[TB] reset during a pending WR_HI");
    applyStimulus(2'd1, 5'd3, 16'h5555);
    @(posedge clk); #1;
    host_word[30:29] = 2'd2; host_word[28:24] = 5'd3; host_word[15:0] = 16'h1111;
    @(posedge clk); #1;
    host_word[31] = ~host_word[31];
    @(posedge clk); #1;
    rst_n = 1'b0;
    modelReset();
    u0 = upd_pulses;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    checkOutput("midrst_cfg3", act_cfg[3], 32'h3F80_0000);
    checkOutput("midrst_gp_out", act_gpout, 32'h0);
    checkOutput("midrst_no_update", 32'(upd_pulses - u0), 32'd0);

    $display("[TB] randomised traffic on the 4-config / 2-status instance");
    @(posedge clk); #1;
    rst_n = 1'b0;
    use_small = 1'b1;
    modelReset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    a0 = ack_toggles; s0 = strobes;
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 3) == 0) stat_w[$urandom_range(0, 1)] = $urandom;
      r_op   = 2'($urandom_range(0, 3));
      r_addr = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      r_data = 16'($urandom);
      applyStimulus(r_op, r_addr, r_data);
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end
    checkOutput("ack_per_strobe", 32'(ack_toggles - a0), 32'(strobes - s0));

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
